// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a single registered response slot per requester.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          PRIO_RESET = 1'b0
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_req0_valid,
  output logic             O_req0_ready,
  input  logic [WIDTH-1:0] I_req0_a,
  input  logic [WIDTH-1:0] I_req0_b,
  input  logic [3:0]       I_req0_op,
  output logic             O_rsp0_valid,
  input  logic             I_rsp0_ready,
  output logic [WIDTH-1:0] O_rsp0_result,
  input  logic             I_req1_valid,
  output logic             O_req1_ready,
  input  logic [WIDTH-1:0] I_req1_a,
  input  logic [WIDTH-1:0] I_req1_b,
  input  logic [3:0]       I_req1_op,
  output logic             O_rsp1_valid,
  input  logic             I_rsp1_ready,
  output logic [WIDTH-1:0] O_rsp1_result,
  output logic [WIDTH-1:0] O_alu_a,
  output logic [WIDTH-1:0] O_alu_b,
  output logic [3:0]       O_alu_op,
  input  logic [WIDTH-1:0] I_alu_result
);

  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data0;
  logic [WIDTH-1:0] rsp_data1;
  logic             last_grant;
  logic             elig0;
  logic             elig1;
  logic             grant0;
  logic             grant1;

  // A requester is eligible only if its slot is free or draining this cycle,
  // so a stalled consumer never blocks the other requester.
  always_comb begin
    elig0  = I_req0_valid && (!rsp_valid[0] || I_rsp0_ready);
    elig1  = I_req1_valid && (!rsp_valid[1] || I_rsp1_ready);
    grant0 = !I_rst && elig0 && (!elig1 || last_grant);
    grant1 = !I_rst && elig1 && (!elig0 || !last_grant);
    O_alu_a  = '0;
    O_alu_b  = '0;
    O_alu_op = '0;
    if (grant0) begin
      O_alu_a  = I_req0_a;
      O_alu_b  = I_req0_b;
      O_alu_op = I_req0_op;
    end else if (grant1) begin
      O_alu_a  = I_req1_a;
      O_alu_b  = I_req1_b;
      O_alu_op = I_req1_op;
    end
  end

  assign O_req0_ready  = grant0;
  assign O_req1_ready  = grant1;
  assign O_rsp0_valid  = rsp_valid[0];
  assign O_rsp1_valid  = rsp_valid[1];
  assign O_rsp0_result = rsp_data0;
  assign O_rsp1_result = rsp_data1;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rsp_valid  <= '0;
      rsp_data0  <= '0;
      rsp_data1  <= '0;
      last_grant <= ~PRIO_RESET;
    end else begin
      if (grant0) begin
        rsp_data0    <= I_alu_result;
        rsp_valid[0] <= 1'b1;
        last_grant   <= 1'b0;
      end else if (rsp_valid[0] && I_rsp0_ready) begin
        rsp_valid[0] <= 1'b0;
      end
      if (grant1) begin
        rsp_data1    <= I_alu_result;
        rsp_valid[1] <= 1'b1;
        last_grant   <= 1'b1;
      end else if (rsp_valid[1] && I_rsp1_ready) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a vector table, directed stall/reset sequences and
// randomized traffic against a slot/priority reference model.
module tb_alu_arbiter;

  localparam bit PRIO = 1'b0;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32), .PRIO_RESET(PRIO)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_req0_valid(req0_valid), .O_req0_ready(req0_ready),
    .I_req0_a(req0_a), .I_req0_b(req0_b), .I_req0_op(req0_op),
    .O_rsp0_valid(rsp0_valid), .I_rsp0_ready(rsp0_ready), .O_rsp0_result(rsp0_result),
    .I_req1_valid(req1_valid), .O_req1_ready(req1_ready),
    .I_req1_a(req1_a), .I_req1_b(req1_b), .I_req1_op(req1_op),
    .O_rsp1_valid(rsp1_valid), .I_rsp1_ready(rsp1_ready), .O_rsp1_result(rsp1_result),
    .O_alu_a(alu_a), .O_alu_b(alu_b), .O_alu_op(alu_op), .I_alu_result(alu_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // External ALU stand-in
  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op0, input logic rr0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] op1, input logic rr1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0; rsp0_ready = rr0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1; rsp1_ready = rr1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op0;
    logic        rr0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  op1;
    logic        rr1;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_rv0;
    logic [31:0] e_r0;
    logic        e_rv1;
    logic [31:0] e_r1;
  } vec_t;

  vec_t vecs[13];

  // Reference model: one result slot per requester plus the preferred winner.
  logic        m_val[2];
  logic [31:0] m_dat[2];
  int          m_prio;

  task automatic rand_step();
    logic e0, e1;
    int w;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    rst        = ($urandom_range(0, 99) == 0);
    req0_valid = ($urandom_range(0, 3) != 0);
    req1_valid = ($urandom_range(0, 3) != 0);
    req0_a = $urandom; req0_b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
    req1_a = $urandom; req1_b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
    req0_op = 4'($urandom_range(0, 15));
    req1_op = 4'($urandom_range(0, 15));
    rsp0_ready = ($urandom_range(0, 2) != 0);
    rsp1_ready = ($urandom_range(0, 2) != 0);
    #3;
    e0 = req0_valid && (!m_val[0] || rsp0_ready);
    e1 = req1_valid && (!m_val[1] || rsp1_ready);
    if (rst) w = -1;
    else if (e0 && e1) w = m_prio;
    else if (e0) w = 0;
    else if (e1) w = 1;
    else w = -1;
    ea  = (w == 0) ? req0_a  : (w == 1) ? req1_a  : 32'd0;
    eb  = (w == 0) ? req0_b  : (w == 1) ? req1_b  : 32'd0;
    eop = (w == 0) ? req0_op : (w == 1) ? req1_op : 4'd0;
    check("rnd_ready0", 32'(req0_ready), 32'(w == 0));
    check("rnd_ready1", 32'(req1_ready), 32'(w == 1));
    check("rnd_alu_a", alu_a, ea);
    check("rnd_alu_b", alu_b, eb);
    check("rnd_alu_op", 32'(alu_op), 32'(eop));
    check("rnd_rsp0_valid", 32'(rsp0_valid), 32'(m_val[0]));
    check("rnd_rsp1_valid", 32'(rsp1_valid), 32'(m_val[1]));
    check("rnd_rsp0_result", rsp0_result, m_dat[0]);
    check("rnd_rsp1_result", rsp1_result, m_dat[1]);
    if (rst) begin
      m_val = '{1'b0, 1'b0};
      m_dat = '{32'd0, 32'd0};
      m_prio = int'(PRIO);
    end else begin
      if (w == 0) begin
        m_dat[0] = alu_fn(req0_a, req0_b, req0_op);
        m_val[0] = 1'b1;
      end else if (m_val[0] && rsp0_ready) m_val[0] = 1'b0;
      if (w == 1) begin
        m_dat[1] = alu_fn(req1_a, req1_b, req1_op);
        m_val[1] = 1'b1;
      end else if (m_val[1] && rsp1_ready) m_val[1] = 1'b0;
      if (w >= 0) m_prio = 1 - w;
    end
    next_cycle();
  endtask

  initial begin
    vecs[0]  = '{1, 5, 3, 0, 1,    0, 0, 0, 0, 1,                     1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 1,    0, 0, 0, 0, 1,                     0, 0, 1, 8, 0, 0};
    vecs[2]  = '{1, 10, 1, 1, 1,   1, 3, 5, 5, 1,                     0, 1, 0, 0, 0, 0};
    vecs[3]  = '{1, 10, 1, 1, 1,   1, 32'hFFFF_FFFF, 1, 6, 1,         1, 0, 0, 0, 1, 1};
    vecs[4]  = '{1, 7, 7, 15, 1,   1, 32'hFFFF_FFFF, 1, 6, 1,         0, 1, 1, 9, 0, 0};
    vecs[5]  = '{1, 7, 7, 15, 1,   1, 32'h8000_0000, 4, 9, 1,         1, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 1,    1, 32'h8000_0000, 4, 9, 1,         0, 1, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 1,    0, 0, 0, 0, 1,                     0, 0, 0, 0, 1, 32'hF800_0000};
    vecs[8]  = '{1, 1, 1, 0, 1,    0, 0, 0, 0, 1,                     1, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 2, 2, 0, 1,    0, 0, 0, 0, 1,                     1, 0, 1, 2, 0, 0};
    vecs[10] = '{1, 3, 3, 0, 1,    0, 0, 0, 0, 1,                     1, 0, 1, 4, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 1,    0, 0, 0, 0, 1,                     0, 0, 1, 6, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1,    0, 0, 0, 0, 1,                     0, 0, 0, 0, 0, 0};

    // Reset with requests pending: nothing accepted, ALU drive quiet
    rst = 1'b1;
    drive(1, 5, 3, 0, 1, 1, 6, 7, 0, 1);
    next_cycle();
    #3;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_result", rsp0_result, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0, vecs[i].rr0,
            vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].rr1);
      #3;
      check($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
      check($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
      check($sformatf("vec%0d_alu_a", i), alu_a,
            vecs[i].e_rdy0 ? vecs[i].a0 : vecs[i].e_rdy1 ? vecs[i].a1 : 32'd0);
      check($sformatf("vec%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(vecs[i].e_rv0));
      check($sformatf("vec%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(vecs[i].e_rv1));
      if (vecs[i].e_rv0) check($sformatf("vec%0d_rsp0_result", i), rsp0_result, vecs[i].e_r0);
      if (vecs[i].e_rv1) check($sformatf("vec%0d_rsp1_result", i), rsp1_result, vecs[i].e_r1);
      next_cycle();
    end

    // Stalled consumer 0: req1 keeps flowing, result0 held, drain-cycle accept
    drive(1, 5, 3, 0, 0, 0, 0, 0, 0, 1);
    #3 check("stall_first_accept", 32'(req0_ready), 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 1, 2, 2, 0, 1);
      #3;
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd1);
      check("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("stall_rsp0_result", rsp0_result, 32'd8);
      next_cycle();
    end
    drive(1, 1, 1, 0, 1, 1, 2, 2, 0, 1);
    #3;
    check("release_ready0", 32'(req0_ready), 32'd1);
    check("release_ready1", 32'(req1_ready), 32'd0);
    check("release_rsp0_result", rsp0_result, 32'd8);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    #3;
    check("release_new_valid", 32'(rsp0_valid), 32'd1);
    check("release_new_result", rsp0_result, 32'd2);
    check("release_rsp1_drained", 32'(rsp1_valid), 32'd0);
    next_cycle();

    // Reset while rsp1 is held
    drive(0, 0, 0, 0, 1, 1, 9, 1, 0, 0);
    #3 check("prerst_ready1", 32'(req1_ready), 32'd1);
    next_cycle();
    rst = 1'b1;
    drive(1, 4, 4, 0, 1, 1, 5, 5, 0, 0);
    #3;
    check("midrst_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("midrst_rsp1_result", rsp1_result, 32'd10);
    check("midrst_ready0", 32'(req0_ready), 32'd0);
    check("midrst_ready1", 32'(req1_ready), 32'd0);
    check("midrst_alu_op_a", alu_a, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1, 4, 4, 0, 1, 1, 5, 5, 0, 1);
    #3;
    check("postrst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("postrst_rsp1_result", rsp1_result, 32'd0);
    check("postrst_rsp0_result", rsp0_result, 32'd0);
    check("postrst_ready0", 32'(req0_ready), 32'(PRIO == 1'b0));
    check("postrst_ready1", 32'(req1_ready), 32'(PRIO == 1'b1));
    next_cycle();

    // Randomized traffic against the reference model
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_val = '{1'b0, 1'b0};
    m_dat = '{32'd0, 32'd0};
    m_prio = int'(PRIO);
    for (int n = 0; n < 3000; n++) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
